fm_param_ctrl: RTL and testbench
================================

FM_PARAM_CTRL -- requirements
Module: fm_param_ctrl

Interface
REQ-001 The parameter CMD_DWIDTH SHALL have default 32 and set the command word width.
REQ-002 The parameter TICK_DIV SHALL have default 1 and mean glide steps occur on every TICK_DIV-th sample_tick (1..255).
REQ-003 Port clk SHALL be an input, 1 bit, and the single clock.
REQ-004 Port reset SHALL be an input, 1 bit, synchronous and active-high.
REQ-005 Port cmd SHALL be an Axis_If.Slave with DWIDTH=CMD_DWIDTH, carrying the command stream (data, valid, ready).
REQ-006 Port sample_tick SHALL be an input, 1 bit, a one-cycle audio-rate strobe.
REQ-007 Port fundamental SHALL be an output, 24 bits, in 14.10 format, driving the synth's fundamental input.
REQ-008 Port harmonicity SHALL be an output, 16 bits, in 3.13 format.
REQ-009 Port mod_index SHALL be an output, 16 bits, in 7.9 format.
REQ-010 Port busy SHALL be an output, 1 bit, high while a mod_index glide is in progress.

Function
REQ-011 A command word SHALL decode as follows: data[31:28] is the address, data[23:0] is the payload, and data[27:24] is ignored.
REQ-012 Addresses SHALL map as follows:
- 0: fundamental shadow, payload[23:0].
- 1: harmonicity shadow, payload[15:0].
- 2: mod_index target shadow, payload[15:0].
- 3: glide rate, payload[15:0], in 7.9 units per step.
- 4: commit, payload ignored.
- Other addresses: accepted, no effect.
REQ-013 A command SHALL be accepted on a cycle with cmd.valid && cmd.ready, and a write SHALL update its shadow register on that edge.
REQ-014 The FSM SHALL have three states: IDLE, APPLY and GLIDE.
REQ-015 cmd.ready SHALL be 1 in IDLE and GLIDE, and 0 in APPLY and during reset.
REQ-016 An accepted commit SHALL move the FSM to APPLY for exactly one cycle; in APPLY, the fundamental and harmonicity shadows SHALL load into their outputs on the same edge (atomic update).
REQ-017 On leaving APPLY, the FSM SHALL take one of three paths:
- Rate == 0: mod_index loads the target directly; go to IDLE.
- mod_index == target: go to IDLE.
- Otherwise: go to GLIDE.
REQ-018 In GLIDE, a step SHALL occur on every TICK_DIV-th sample_tick, counted by a tick counter cleared on entry to GLIDE.
REQ-019 Each step SHALL move mod_index toward the target by rate; if |target − mod_index| <= rate, mod_index SHALL equal the target and the FSM SHALL go to IDLE.
REQ-020 Glide arithmetic SHALL be unsigned 16-bit with a 17-bit difference, and mod_index SHALL never overshoot, underflow or wrap.
REQ-021 A commit accepted during GLIDE SHALL go to APPLY and then resume from the current mod_index toward the new target, with the tick counter cleared.
REQ-022 A sample_tick coinciding with commit acceptance or with APPLY SHALL be ignored.
REQ-023 Shadow writes without a commit SHALL leave the outputs unchanged.
REQ-024 busy SHALL equal (state == GLIDE), registered.
REQ-025 All outputs SHALL be registered, with a latency of 2 cycles from commit acceptance to the fundamental and harmonicity update.

Reset
REQ-026 On reset, fundamental and its shadow SHALL be 24'd450560 (440.0 Hz).
REQ-027 On reset, harmonicity and its shadow SHALL be 16'h2000 (1.0).
REQ-028 On reset, mod_index, the target, the rate and the tick counter SHALL be 0.
REQ-029 On reset, the state SHALL be IDLE, busy SHALL be 0 and cmd.ready SHALL be 0.
REQ-030 Reset asserted mid-glide SHALL abandon the glide and restore all reset values on the next edge; cmd.ready SHALL return to 1 on the cycle after reset deasserts.

Structure
REQ-031 Package fm_pkg SHALL hold:
- the address enum (ADDR_FUND, ADDR_HARM, ADDR_MIDX, ADDR_RATE, ADDR_COMMIT);
- the state enum;
- the reset constants FUND_RST and HARM_RST;
- the field-width constants.
REQ-032 Sub-module glide_step SHALL be the only sub-module: a combinational step toward the target with saturation, taking cur, tgt and rate and returning next and done.

Verification
REQ-033 Atomic update: write fund=0x070000, write harm=0x4000, then commit -> both outputs change on the same cycle, 2 cycles after the commit; no output changes before the commit.
REQ-034 Glide up: TICK_DIV=1, rate=0x0100, target=0x0500, commit -> mod_index steps 0x100, 0x200 … 0x500 on successive ticks; busy falls with the 0x500 step.
REQ-035 Glide down with remainder: mod_index=0x0500, rate=0x0180, target=0x0000 -> mod_index steps 0x380, 0x200, 0x080, 0x000, with no underflow.
REQ-036 Retarget mid-glide: commit a new target 0x0100 while at 0x0300 rising -> mod_index reverses from 0x0300, and cmd.ready is low for exactly one cycle.
REQ-037 Immediate mode and ignored address: with rate=0, commit target 0x1234 -> mod_index=0x1234 two cycles later with busy never high; a write to address 7 -> accepted, all outputs and shadows unchanged.
REQ-038 Reset mid-glide: assert reset during GLIDE -> next cycle outputs are 450560 / 0x2000 / 0, busy=0, ready=0.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and constants for the FM synth parameter controller.
package fm_pkg;

    localparam int unsigned FUND_W    = 24;
    localparam int unsigned HARM_W    = 16;
    localparam int unsigned MIDX_W    = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned ADDR_LSB  = 28;
    localparam int unsigned PAYLOAD_W = 24;
    localparam int unsigned TICK_W    = 8;

    localparam logic [FUND_W-1:0] FUND_RST = 24'd450560;  // 440.0 Hz in 14.10
    localparam logic [HARM_W-1:0] HARM_RST = 16'h2000;    // 1.0 in 3.13

    typedef enum logic [ADDR_W-1:0] {
        ADDR_FUND   = 4'd0,
        ADDR_HARM   = 4'd1,
        ADDR_MIDX   = 4'd2,
        ADDR_RATE   = 4'd3,
        ADDR_COMMIT = 4'd4
    } addr_e;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        GLIDE
    } state_e;

endpackage

// File: rtl/Axis_If.sv
// Minimal AXI-Stream style command channel: data, valid, ready.
interface Axis_If #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;

    modport Master (output data, output valid, input ready);
    modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/glide_step.sv
// One saturating step of cur toward tgt by rate; done when the target is reached.
module glide_step
    import fm_pkg::*;
(
    input  logic [MIDX_W-1:0] cur,
    input  logic [MIDX_W-1:0] tgt,
    input  logic [MIDX_W-1:0] rate,
    output logic [MIDX_W-1:0] next,
    output logic              done
);

    logic            up;
    logic [MIDX_W:0] diff;

    always_comb begin
        up   = (tgt >= cur);
        diff = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        // Within one step of the target: land exactly on it, never overshoot.
        done = (diff <= {1'b0, rate});
        if (done) begin
            next = tgt;
        end else if (up) begin
            next = cur + rate;
        end else begin
            next = cur - rate;
        end
    end

endmodule

// File: rtl/fm_param_ctrl.sv
// FM synth parameter controller: shadowed register writes, atomic commit and
// tick-paced mod_index glide.
module fm_param_ctrl
    import fm_pkg::*;
#(
    parameter int unsigned CMD_DWIDTH = 32,
    parameter int unsigned TICK_DIV   = 1
) (
    input  logic              clk,
    input  logic              reset,
    Axis_If.Slave             cmd,
    input  logic              sample_tick,
    output logic [FUND_W-1:0] fundamental,
    output logic [HARM_W-1:0] harmonicity,
    output logic [MIDX_W-1:0] mod_index,
    output logic              busy
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic [FUND_W-1:0]   fund_q, fund_d, fund_sh_q, fund_sh_d;
    logic [HARM_W-1:0]   harm_q, harm_d, harm_sh_q, harm_sh_d;
    logic [MIDX_W-1:0]   midx_q, midx_d, tgt_sh_q, tgt_sh_d, tgt_q, tgt_d;
    logic [MIDX_W-1:0]   rate_sh_q, rate_sh_d, rate_q, rate_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                busy_q, busy_d, ready_q, ready_d;

    addr_e                addr;
    logic [PAYLOAD_W-1:0] payload;
    logic                 accept, commit, glide_tick, step_en;
    logic [MIDX_W-1:0]    step_next;
    logic                 step_done;
    logic                 unused_data;

    assign addr        = addr_e'(cmd.data[ADDR_LSB +: ADDR_W]);
    assign payload     = cmd.data[PAYLOAD_W-1:0];
    assign unused_data = ^cmd.data[ADDR_LSB-1:PAYLOAD_W];
    assign accept      = cmd.valid && ready_q;
    assign commit      = accept && (addr == ADDR_COMMIT);
    // Ticks racing a commit are dropped; APPLY never counts ticks.
    assign glide_tick  = (state_q == GLIDE) && sample_tick && !commit;
    assign step_en     = glide_tick && (tick_cnt_q == TICK_LAST);

    glide_step u_glide_step (
        .cur  (midx_q),
        .tgt  (tgt_q),
        .rate (rate_q),
        .next (step_next),
        .done (step_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (commit) state_d = APPLY;
            end
            APPLY: begin
                if (rate_sh_q == '0 || midx_q == tgt_sh_q) state_d = IDLE;
                else                                        state_d = GLIDE;
            end
            GLIDE: begin
                if (commit)                      state_d = APPLY;
                else if (step_en && step_done)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fund_sh_d  = fund_sh_q;
        harm_sh_d  = harm_sh_q;
        tgt_sh_d   = tgt_sh_q;
        rate_sh_d  = rate_sh_q;
        fund_d     = fund_q;
        harm_d     = harm_q;
        midx_d     = midx_q;
        tgt_d      = tgt_q;
        rate_d     = rate_q;
        tick_cnt_d = tick_cnt_q;

        if (accept) begin
            case (addr)
                ADDR_FUND: fund_sh_d = payload;
                ADDR_HARM: harm_sh_d = payload[HARM_W-1:0];
                ADDR_MIDX: tgt_sh_d  = payload[MIDX_W-1:0];
                ADDR_RATE: rate_sh_d = payload[MIDX_W-1:0];
                default:   ;
            endcase
        end

        if (state_q == APPLY) begin
            fund_d     = fund_sh_q;
            harm_d     = harm_sh_q;
            tgt_d      = tgt_sh_q;
            rate_d     = rate_sh_q;
            tick_cnt_d = '0;
            if (rate_sh_q == '0) midx_d = tgt_sh_q;
        end else if (glide_tick) begin
            if (step_en) begin
                tick_cnt_d = '0;
                midx_d     = step_next;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end

        busy_d  = (state_d == GLIDE);
        ready_d = (state_d != APPLY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fund_q     <= FUND_RST;
            fund_sh_q  <= FUND_RST;
            harm_q     <= HARM_RST;
            harm_sh_q  <= HARM_RST;
            midx_q     <= '0;
            tgt_sh_q   <= '0;
            tgt_q      <= '0;
            rate_sh_q  <= '0;
            rate_q     <= '0;
            tick_cnt_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            fund_q     <= fund_d;
            fund_sh_q  <= fund_sh_d;
            harm_q     <= harm_d;
            harm_sh_q  <= harm_sh_d;
            midx_q     <= midx_d;
            tgt_sh_q   <= tgt_sh_d;
            tgt_q      <= tgt_d;
            rate_sh_q  <= rate_sh_d;
            rate_q     <= rate_d;
            tick_cnt_q <= tick_cnt_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd.ready   = ready_q;
    assign fundamental = fund_q;
    assign harmonicity = harm_q;
    assign mod_index   = midx_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fm_param_ctrl.sv
// Directed bench for fm_param_ctrl: commit table plus glide, retarget and reset sequences.
module tb_fm_param_ctrl;
    import fm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sample_tick;
    logic [23:0] fund, fund3;
    logic [15:0] harm, harm3, midx, midx3;
    logic        busy, busy3;

    Axis_If #(.DWIDTH(32)) cmd_if ();
    Axis_If #(.DWIDTH(32)) cmd3_if ();
    assign cmd3_if.data  = cmd_if.data;
    assign cmd3_if.valid = cmd_if.valid;

    fm_param_ctrl #(.CMD_DWIDTH(32), .TICK_DIV(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd_if),
        .sample_tick (sample_tick),
        .fundamental (fund),
        .harmonicity (harm),
        .mod_index   (midx),
        .busy        (busy)
    );

    fm_param_ctrl #(.CMD_DWIDTH(32), .TICK_DIV(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd3_if),
        .sample_tick (sample_tick),
        .fundamental (fund3),
        .harmonicity (harm3),
        .mod_index   (midx3),
        .busy        (busy3)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  junk;
        logic [23:0] payload;
        logic [23:0] exp_fund;
        logic [15:0] exp_harm;
        logic [15:0] exp_midx;
    } vec_t;

    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds valid until ready, then returns #1 after the accepting edge.
    task automatic send(input logic [3:0] addr, input logic [3:0] junk, input logic [23:0] pl);
        int n;
        n = 0;
        cmd_if.data  = {addr, junk, pl};
        cmd_if.valid = 1'b1;
        while (!cmd_if.ready && n < 20) begin
            cyc();
            n++;
        end
        if (!cmd_if.ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready got 0 expected 1");
        end
        cyc();
        cmd_if.valid = 1'b0;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pf;
        logic [15:0] ph, pm;
        logic [15:0] down_exp[4];

        vecs[0] = '{4'h1, 4'h5, 24'hAB1234, 24'h070000, 16'h1234, 16'h0000};
        vecs[1] = '{4'h2, 4'hF, 24'hFF1234, 24'h070000, 16'h1234, 16'h1234};
        vecs[2] = '{4'h7, 4'h0, 24'h123456, 24'h070000, 16'h1234, 16'h1234};
        vecs[3] = '{4'h5, 4'h0, 24'h000001, 24'h070000, 16'h1234, 16'h1234};
        vecs[4] = '{4'h0, 4'hA, 24'hFFFFFF, 24'hFFFFFF, 16'h1234, 16'h1234};
        vecs[5] = '{4'h2, 4'h0, 24'h000000, 24'hFFFFFF, 16'h1234, 16'h0000};
        vecs[6] = '{4'hF, 4'h3, 24'hABCDEF, 24'hFFFFFF, 16'h1234, 16'h0000};
        vecs[7] = '{4'h0, 4'h0, 24'h0ABCDE, 24'h0ABCDE, 16'h1234, 16'h0000};
        down_exp = '{16'h0380, 16'h0200, 16'h0080, 16'h0000};

        reset        = 1'b1;
        sample_tick  = 1'b0;
        cmd_if.valid = 1'b0;
        cmd_if.data  = '0;
        cyc();
        cyc();
        check("rst_fund", 32'(fund), 32'd450560);
        check("rst_harm", 32'(harm), 32'h2000);
        check("rst_midx", 32'(midx), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(cmd_if.ready), 32'h0);
        reset = 1'b0;
        cyc();
        check("ready_after_rst", 32'(cmd_if.ready), 32'h1);
        check("ready3_after_rst", 32'(cmd3_if.ready), 32'h1);

        // Atomic update: nothing moves until two cycles after the commit.
        send(4'h0, 4'h0, 24'h070000);
        check("atom_fund_hold", 32'(fund), 32'd450560);
        send(4'h1, 4'h0, 24'h004000);
        check("atom_harm_hold", 32'(harm), 32'h2000);
        send(4'h4, 4'h0, 24'h000000);
        check("atom_apply_ready", 32'(cmd_if.ready), 32'h0);
        check("atom_apply_fund", 32'(fund), 32'd450560);
        check("atom_apply_harm", 32'(harm), 32'h2000);
        cyc();
        check("atom_fund", 32'(fund), 32'h070000);
        check("atom_harm", 32'(harm), 32'h4000);
        check("atom_ready", 32'(cmd_if.ready), 32'h1);
        check("atom_busy", 32'(busy), 32'h0);
        check("atom_fund3", 32'(fund3), 32'h070000);
        check("atom_harm3", 32'(harm3), 32'h4000);

        pf = 24'h070000;
        ph = 16'h4000;
        pm = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].addr, vecs[i].junk, vecs[i].payload);
            check($sformatf("row%0d_pre_fund", i), 32'(fund), 32'(pf));
            check($sformatf("row%0d_pre_harm", i), 32'(harm), 32'(ph));
            check($sformatf("row%0d_pre_midx", i), 32'(midx), 32'(pm));
            send(4'h4, 4'h0, 24'h0);
            cyc();
            check($sformatf("row%0d_fund", i), 32'(fund), 32'(vecs[i].exp_fund));
            check($sformatf("row%0d_harm", i), 32'(harm), 32'(vecs[i].exp_harm));
            check($sformatf("row%0d_midx", i), 32'(midx), 32'(vecs[i].exp_midx));
            check($sformatf("row%0d_busy", i), 32'(busy), 32'h0);
            pf = vecs[i].exp_fund;
            ph = vecs[i].exp_harm;
            pm = vecs[i].exp_midx;
        end

        // Glide up 0 -> 0x500 by 0x100 per tick; dut3 steps every third tick.
        send(4'h3, 4'h0, 24'h000100);
        send(4'h2, 4'h0, 24'h000500);
        send(4'h4, 4'h0, 24'h000000);
        check("up_apply_busy", 32'(busy), 32'h0);
        cyc();
        check("up_start_busy", 32'(busy), 32'h1);
        check("up_start_midx", 32'(midx), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            pulse_tick();
            check($sformatf("up%0d_midx", k), 32'(midx), 32'(k * 'h100));
            check($sformatf("up%0d_busy", k), 32'(busy), (k == 5) ? 32'h0 : 32'h1);
            check($sformatf("up%0d_midx3", k), 32'(midx3), (k >= 3) ? 32'h100 : 32'h0);
            cyc();
            check($sformatf("up%0d_hold", k), 32'(midx), 32'(k * 'h100));
        end

        // Glide down with a remainder on the last step.
        send(4'h3, 4'h0, 24'h000180);
        send(4'h2, 4'h0, 24'h000000);
        send(4'h4, 4'h0, 24'h000000);
        cyc();
        check("dn_start_busy", 32'(busy), 32'h1);
        check("dn_start_midx", 32'(midx), 32'h500);
        for (int k = 0; k < 4; k++) begin
            pulse_tick();
            check($sformatf("dn%0d_midx", k), 32'(midx), 32'(down_exp[k]));
            check($sformatf("dn%0d_busy", k), 32'(busy), (k == 3) ? 32'h0 : 32'h1);
        end

        // Retarget mid-glide; ticks at commit acceptance and in APPLY are dropped.
        send(4'h3, 4'h0, 24'h000100);
        send(4'h2, 4'h0, 24'h000500);
        send(4'h4, 4'h0, 24'h000000);
        cyc();
        for (int k = 1; k <= 3; k++) begin
            pulse_tick();
            check($sformatf("rt_up%0d_midx", k), 32'(midx), 32'(k * 'h100));
        end
        send(4'h2, 4'h0, 24'h000100);
        check("rt_shadow_midx", 32'(midx), 32'h300);
        check("rt_shadow_busy", 32'(busy), 32'h1);
        cmd_if.data  = {4'h4, 4'h0, 24'h0};
        cmd_if.valid = 1'b1;
        sample_tick  = 1'b1;
        check("rt_ready_pre", 32'(cmd_if.ready), 32'h1);
        cyc();
        cmd_if.valid = 1'b0;
        check("rt_ready_apply", 32'(cmd_if.ready), 32'h0);
        check("rt_midx_accept", 32'(midx), 32'h300);
        cyc();
        sample_tick = 1'b0;
        check("rt_ready_back", 32'(cmd_if.ready), 32'h1);
        check("rt_midx_apply", 32'(midx), 32'h300);
        check("rt_busy", 32'(busy), 32'h1);
        pulse_tick();
        check("rt_dn1_midx", 32'(midx), 32'h200);
        check("rt_dn1_busy", 32'(busy), 32'h1);
        pulse_tick();
        check("rt_dn2_midx", 32'(midx), 32'h100);
        check("rt_dn2_busy", 32'(busy), 32'h0);

        // Reset in the middle of a glide.
        send(4'h2, 4'h0, 24'h000500);
        send(4'h4, 4'h0, 24'h000000);
        cyc();
        pulse_tick();
        check("mr_midx", 32'(midx), 32'h200);
        check("mr_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        cyc();
        check("mr_rst_fund", 32'(fund), 32'd450560);
        check("mr_rst_harm", 32'(harm), 32'h2000);
        check("mr_rst_midx", 32'(midx), 32'h0);
        check("mr_rst_busy", 32'(busy), 32'h0);
        check("mr_rst_ready", 32'(cmd_if.ready), 32'h0);
        reset = 1'b0;
        cyc();
        check("mr_ready_back", 32'(cmd_if.ready), 32'h1);
        send(4'h4, 4'h0, 24'h000000);
        cyc();
        check("mr_commit_fund", 32'(fund), 32'd450560);
        check("mr_commit_harm", 32'(harm), 32'h2000);
        check("mr_commit_midx", 32'(midx), 32'h0);
        check("mr_commit_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
